// File: rtl/nf_trace_pkg.sv
// Shared types for the nanoFOX retired-instruction trace buffer.
// Optional timestamp field is controlled by NF_TRACE_TS_EN.
package nf_trace_pkg;

  localparam int TR_ADDR_W  = 32;
  localparam int TR_INSTR_W = 32;
  localparam int TR_TS_W    = 32;

  localparam logic TR_FILL = 1'b0;
  localparam logic TR_CIRC = 1'b1;

  typedef enum logic [1:0] {TR_IDLE, TR_RUN, TR_HALT} tr_st_t;

  typedef struct packed {
    logic [TR_ADDR_W-1:0]  pc;
    logic [TR_INSTR_W-1:0] instr;
`ifdef NF_TRACE_TS_EN
    logic [TR_TS_W-1:0]    ts;
`endif
  } trace_ent_t;

endpackage

// File: rtl/nf_trace_mem.sv
// Simple dual-port trace storage: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module nf_trace_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 64,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // storage array, no reset: contents are meaningless until written
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read; non-blocking update gives read-before-write
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/nf_trace_buf.sv
// Retired-instruction trace buffer for nanoFOX: captures {pc, instr} on each
// rising edge of cpu_en, fill-and-drop or circular storage, halt after STOP_CNT.
// Define NF_TRACE_TS_EN to store a free-running cycle timestamp per entry.
module nf_trace_buf
  import nf_trace_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = TR_ADDR_W,
  parameter int INSTR_W  = TR_INSTR_W,
  parameter int CNT_W    = 32,
  parameter int STOP_CNT = 200
`ifdef NF_TRACE_TS_EN
  , parameter int TS_W   = TR_TS_W
`endif
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cpu_en,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [INSTR_W-1:0]       instr,
  input  logic                     enable,
  input  logic                     mode,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [ADDR_W-1:0]        rd_pc,
  output logic [INSTR_W-1:0]       rd_instr,
`ifdef NF_TRACE_TS_EN
  output logic [TS_W-1:0]          rd_ts,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic                     halt_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // resetn is active-high despite its name
  logic rst;
  assign rst = resetn;

  logic          cpu_en_q;
  tr_st_t        st, st_nx;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ev, pop, full, push, ovf_ev, overwrite, last_ev, inc, dec;
  trace_ent_t    wdata, rdata;

  assign ev   = cpu_en & ~cpu_en_q & enable & (st == TR_RUN);
  assign full = (cnt == CW'(DEPTH));
  assign pop  = rd_req & (cnt != '0);

  // full + concurrent pop is a plain push/pop; only an unpaired full event overflows
  assign ovf_ev    = ev & full & ~pop;
  assign overwrite = ovf_ev & (mode == TR_CIRC);
  assign push      = ev & ~(ovf_ev & (mode == TR_FILL));
  assign inc       = push & ~pop & ~full;
  assign dec       = pop & ~push;

  assign last_ev = ev && (STOP_CNT != 0) && (retire_cnt == CNT_W'(STOP_CNT - 1));

  // strobe edge detect
  always_ff @(posedge clk) begin
    if (rst) cpu_en_q <= 1'b0;
    else     cpu_en_q <= cpu_en;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) st <= TR_IDLE;
    else     st <= st_nx;
  end

  // next-state: HALT is sticky until reset
  always_comb begin
    st_nx = st;
    case (st)
      TR_IDLE: if (enable) st_nx = TR_RUN;
      TR_RUN: begin
        if (last_ev)      st_nx = TR_HALT;
        else if (!enable) st_nx = TR_IDLE;
      end
      TR_HALT: st_nx = TR_HALT;
      default: st_nx = TR_IDLE;
    endcase
  end

  // pointers and occupancy; occupancy is its own counter so full and empty differ
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)             wr_ptr <= wr_ptr + 1'b1;
      if (pop || overwrite) rd_ptr <= rd_ptr + 1'b1;
      if (inc)              cnt    <= cnt + 1'b1;
      else if (dec)         cnt    <= cnt - 1'b1;
    end
  end

  // retirement and overflow statistics; overflow saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
      ovf_cnt    <= '0;
    end else begin
      if (ev)                       retire_cnt <= retire_cnt + 1'b1;
      if (ovf_ev && (~ovf_cnt != 0)) ovf_cnt   <= ovf_cnt + 1'b1;
    end
  end

  // read data is valid the cycle after an accepted pop
  always_ff @(posedge clk) begin
    if (rst) rd_valid <= 1'b0;
    else     rd_valid <= pop;
  end

`ifdef NF_TRACE_TS_EN
  logic [TS_W-1:0] ts_cnt;

  // free-running cycle counter sampled into each captured entry
  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  // pack the captured entry
  always_comb begin
    wdata       = '0;
    wdata.pc    = pc;
    wdata.instr = instr;
`ifdef NF_TRACE_TS_EN
    wdata.ts    = ts_cnt;
`endif
  end

  nf_trace_mem #(
    .DEPTH (DEPTH),
    .W     ($bits(trace_ent_t))
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign rd_pc    = rdata.pc;
  assign rd_instr = rdata.instr;
`ifdef NF_TRACE_TS_EN
  assign rd_ts    = rdata.ts;
`endif
  assign count    = cnt;
  assign halt_req = (st == TR_HALT);

endmodule
